// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_pkg : shared FSM encoding and defaults for the I2C req arbiter    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FINISH = 2'd3
    } arb_state_t;

    localparam int c_start_timeout_def = 1024;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_req_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : round-robin selector, search starts one past ptr            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        w_cand = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!valid && req[w_cand]) begin
                valid          = 1'b1;
                idx            = w_cand;
                winner[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_req_arbiter : shares one I2C master among N_REQ requesters        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = c_start_timeout_def
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*7-1:0] req_addr,
    input  logic [N_REQ-1:0]   req_rnw,
    input  logic [N_REQ*2-1:0] req_size,
    input  logic [N_REQ*8-1:0] req_wdata,
    input  logic [N_REQ-1:0]   req_wvalid,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   wready,
    output logic [7:0]         rdata,
    output logic [N_REQ-1:0]   rvalid,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic               m_start,
    output logic [6:0]         m_addr,
    output logic               m_rnw,
    output logic [1:0]         m_size,
    output logic [7:0]         m_data,
    output logic               m_data_valid,
    input  logic               m_busy,
    input  logic               m_dataReq,
    input  logic               m_newData,
    input  logic [7:0]         m_data_o
);

    localparam int c_idx_w  = idx_w(N_REQ);
    localparam int c_tcnt_w = $clog2(START_TIMEOUT) + 1;

    arb_state_t          r_state, w_state_nxt;
    logic [N_REQ-1:0]    r_gnt;
    logic [c_idx_w-1:0]  r_win;
    logic [c_idx_w-1:0]  r_ptr;
    logic [6:0]          r_addr;
    logic                r_rnw;
    logic [1:0]          r_size;
    logic [c_tcnt_w-1:0] r_tcnt;
    logic                r_nd_q;
    logic                r_busy_q;
    logic [7:0]          r_rdata;
    logic [N_REQ-1:0]    r_rvalid;
    logic [N_REQ-1:0]    r_done;
    logic [N_REQ-1:0]    r_err;

    logic [N_REQ-1:0]    w_pick_oh;
    logic [c_idx_w-1:0]  w_pick_idx;
    logic                w_pick_vld;
    logic                w_grant;
    logic                w_timeout;
    logic                w_busy_fall;
    logic                w_nd_rise;
    logic [6:0]          w_sel_addr;
    logic                w_sel_rnw;
    logic [1:0]          w_sel_size;
    logic [7:0]          w_gnt_wdata;
    logic                w_gnt_wvalid;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (c_idx_w)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_pick_oh),
        .idx    (w_pick_idx),
        .valid  (w_pick_vld)
    );

    assign w_busy_fall = r_busy_q & ~m_busy;
    assign w_nd_rise   = m_newData & ~r_nd_q;

    // Field muxes: winner-of-pick for latching, current grant for write data.
    always_comb begin
        w_sel_addr   = '0;
        w_sel_rnw    = 1'b0;
        w_sel_size   = '0;
        w_gnt_wdata  = '0;
        w_gnt_wvalid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick_oh[i]) begin
                w_sel_addr = req_addr[i*7 +: 7];
                w_sel_rnw  = req_rnw[i];
                w_sel_size = req_size[i*2 +: 2];
            end
            if (r_gnt[i]) begin
                w_gnt_wdata  = req_wdata[i*8 +: 8];
                w_gnt_wvalid = req_wvalid[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld && !m_busy) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_busy) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (r_tcnt == c_tcnt_w'(START_TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_busy_fall) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt    <= '0;
            r_win    <= '0;
            r_ptr    <= c_idx_w'(N_REQ - 1);
            r_addr   <= '0;
            r_rnw    <= 1'b0;
            r_size   <= '0;
            r_tcnt   <= '0;
            r_nd_q   <= 1'b0;
            r_busy_q <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= '0;
            r_done   <= '0;
            r_err    <= '0;
        end else begin
            r_rvalid <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_nd_q   <= m_newData;
            r_busy_q <= m_busy;

            if (w_grant) begin
                r_gnt  <= w_pick_oh;
                r_win  <= w_pick_idx;
                r_addr <= w_sel_addr;
                r_rnw  <= w_sel_rnw;
                r_size <= w_sel_size;
                r_tcnt <= '0;
            end

            if (r_state == ST_ISSUE && !m_busy && !w_timeout) begin
                r_tcnt <= r_tcnt + c_tcnt_w'(1);
            end

            if (w_timeout) begin
                r_err <= r_gnt;
                r_gnt <= '0;
            end

            // done is visible during FINISH while the grant is still held
            if (r_state == ST_ACTIVE && w_busy_fall) begin
                r_done <= r_gnt;
            end

            if (r_state == ST_FINISH) begin
                r_ptr <= r_win;
                r_gnt <= '0;
            end

            if (r_state == ST_ACTIVE && w_nd_rise) begin
                r_rdata  <= m_data_o;
                r_rvalid <= r_gnt;
            end
        end
    end

    assign gnt          = r_gnt;
    assign rdata        = r_rdata;
    assign rvalid       = r_rvalid;
    assign done         = r_done;
    assign err          = r_err;
    assign m_start      = (r_state == ST_ISSUE);
    assign m_addr       = r_addr;
    assign m_rnw        = r_rnw;
    assign m_size       = r_size;
    assign m_data       = (r_state == ST_ACTIVE) ? w_gnt_wdata : 8'h00;
    assign m_data_valid = (r_state == ST_ACTIVE) ? w_gnt_wvalid : 1'b0;
    assign wready       = (r_state == ST_ACTIVE && m_dataReq) ? r_gnt : '0;

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i2c_req_arbiter : scoreboard bench with a behavioural I2C master   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_i2c_req_arbiter;

    localparam int N = 4;
    localparam int T = 40;
    localparam logic [7:0] K_GNT  = 8'd1;
    localparam logic [7:0] K_WR   = 8'd2;
    localparam logic [7:0] K_RD   = 8'd3;
    localparam logic [7:0] K_DONE = 8'd4;
    localparam logic [7:0] K_ERR  = 8'd5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req;
    logic [N*7-1:0] req_addr;
    logic [N-1:0]   req_rnw;
    logic [N*2-1:0] req_size;
    logic [N*8-1:0] req_wdata;
    logic [N-1:0]   req_wvalid;
    logic [N-1:0]   gnt, wready, rvalid, done, err;
    logic [7:0]     rdata;
    logic           m_start, m_rnw, m_data_valid;
    logic [6:0]     m_addr;
    logic [1:0]     m_size;
    logic [7:0]     m_data;
    logic           m_busy, m_dataReq, m_newData;
    logic [7:0]     m_data_o;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] sb_q[$];
    logic [N-1:0] prev_gnt = '0;

    always #5 clk = ~clk;

    i2c_req_arbiter #(.N_REQ(N), .START_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rnw(req_rnw),
        .req_size(req_size), .req_wdata(req_wdata), .req_wvalid(req_wvalid),
        .gnt(gnt), .wready(wready), .rdata(rdata), .rvalid(rvalid), .done(done),
        .err(err), .m_start(m_start), .m_addr(m_addr), .m_rnw(m_rnw), .m_size(m_size),
        .m_data(m_data), .m_data_valid(m_data_valid), .m_busy(m_busy),
        .m_dataReq(m_dataReq), .m_newData(m_newData), .m_data_o(m_data_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [7:0] k, input int idx, input logic [7:0] d);
        return {k, 8'(idx), 8'h00, d};
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        int r = 255;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic sb_pop(input string tag, input logic [31:0] got);
        logic [31:0] e = 32'h0;
        if (sb_q.size() != 0) e = sb_q.pop_front();
        chk(tag, got, e);
    endtask

    // Output monitor: every observable event must match the head of the scoreboard.
    always @(negedge clk) begin
        chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
        if (gnt != '0 && gnt != prev_gnt) sb_pop("grant", ev(K_GNT, oh2idx(gnt), 8'h00));
        if (m_dataReq && m_data_valid && gnt != '0) begin
            chk("wready", 32'(wready), 32'(gnt));
            sb_pop("wbyte", ev(K_WR, oh2idx(gnt), m_data));
        end
        if (rvalid != '0) sb_pop("rbyte", ev(K_RD, oh2idx(rvalid), rdata));
        if (done != '0)   sb_pop("done", ev(K_DONE, oh2idx(done), 8'h00));
        if (err != '0)    sb_pop("err", ev(K_ERR, oh2idx(err), 8'h00));
        prev_gnt = gnt;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        int t = 0;
        while (!m_start && t < 50) begin tick(1); t++; end
        ok = m_start;
        if (!ok) chk("start_seen", 32'd0, 32'd1);
    endtask

    // Behavioural master: accepts start, raises busy, moves bytes, releases busy.
    task automatic serve(input logic [6:0] ea, input logic er, input logic [1:0] es,
                         input int nbytes, input logic [7:0] d0, input logic [7:0] d1,
                         input bit setq, input logic [N-1:0] nq);
        bit ok;
        wait_start(ok);
        if (!ok) return;
        chk("m_addr", 32'(m_addr), 32'(ea));
        chk("m_rnw", 32'(m_rnw), 32'(er));
        chk("m_size", 32'(m_size), 32'(es));
        if (setq) req = nq;
        tick(2);
        m_busy = 1'b1;
        tick(1);
        chk("start_drop", 32'(m_start), 32'd0);
        for (int b = 0; b < nbytes; b++) begin
            if (!er) begin
                m_dataReq = 1'b1; tick(1); m_dataReq = 1'b0;
            end else begin
                m_data_o  = (b == 0) ? d0 : d1;
                m_newData = 1'b1; tick(3); m_newData = 1'b0;
            end
            tick(2);
        end
        m_busy = 1'b0;
    endtask

    task automatic drain(input int bound);
        int t = 0;
        while (sb_q.size() != 0 && t < bound) begin tick(1); t++; end
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int  order[8] = '{0, 1, 2, 3, 0, 2, 0, 2};
        int  cnt;
        bit  ok;
        req = '0; req_addr = '0; req_rnw = '0; req_size = '0; req_wdata = '0; req_wvalid = '0;
        m_busy = 1'b0; m_dataReq = 1'b0; m_newData = 1'b0; m_data_o = '0;

        rst = 1'b1; tick(3);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mstart", 32'(m_start), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b0; tick(1);

        // single write, requester drops req after grant
        req_addr[13:7] = 7'h50; req_rnw[1] = 1'b0; req_size[3:2] = 2'd0;
        req_wdata[15:8] = 8'hA5; req_wvalid[1] = 1'b1;
        sb_q.push_back(ev(K_GNT, 1, 8'h00));
        sb_q.push_back(ev(K_WR, 1, 8'hA5));
        sb_q.push_back(ev(K_DONE, 1, 8'h00));
        req = 4'b0010;
        serve(7'h50, 1'b0, 2'd0, 1, 8'h00, 8'h00, 1'b1, 4'b0000);
        drain(20);
        chk("wr_gnt_clear", 32'(gnt), 32'd0);

        // two-byte read with a wide newData strobe
        req_addr[20:14] = 7'h2A; req_rnw[2] = 1'b1; req_size[5:4] = 2'd1;
        sb_q.push_back(ev(K_GNT, 2, 8'h00));
        sb_q.push_back(ev(K_RD, 2, 8'h3C));
        sb_q.push_back(ev(K_RD, 2, 8'hC3));
        sb_q.push_back(ev(K_DONE, 2, 8'h00));
        req = 4'b0100;
        serve(7'h2A, 1'b1, 2'd1, 2, 8'h3C, 8'hC3, 1'b1, 4'b0000);
        drain(20);
        chk("rd_gnt_clear", 32'(gnt), 32'd0);

        // contention after reset: 1111 then 0101
        rst = 1'b1; tick(2); rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*7 +: 7] = 7'(32 + i); req_rnw[i] = 1'b0; req_size[i*2 +: 2] = 2'd0;
            req_wdata[i*8 +: 8] = 8'(16 + i); req_wvalid[i] = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            sb_q.push_back(ev(K_GNT, order[k], 8'h00));
            sb_q.push_back(ev(K_WR, order[k], 8'(16 + order[k])));
            sb_q.push_back(ev(K_DONE, order[k], 8'h00));
        end
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            serve(7'(32 + order[k]), 1'b0, 2'd0, 1, 8'h00, 8'h00,
                  (k == 3 || k == 7), (k == 3) ? 4'b0101 : 4'b0000);
        end
        drain(20);

        // start timeout with the master never going busy
        sb_q.push_back(ev(K_GNT, 3, 8'h00));
        sb_q.push_back(ev(K_ERR, 3, 8'h00));
        req = 4'b1000;
        wait_start(ok);
        req = '0;
        cnt = 0;
        while (err[3] !== 1'b1 && cnt < T + 10) begin tick(1); cnt++; end
        chk("to_cycles", 32'(cnt), 32'(T));
        chk("to_gnt", 32'(gnt), 32'd0);
        tick(1);
        chk("to_mstart", 32'(m_start), 32'd0);
        drain(5);

        // bus held by a foreign master
        sb_q.push_back(ev(K_GNT, 0, 8'h00));
        sb_q.push_back(ev(K_WR, 0, 8'h10));
        sb_q.push_back(ev(K_DONE, 0, 8'h00));
        m_busy = 1'b1; req = 4'b0001;
        tick(5);
        chk("fh_nognt", 32'(gnt), 32'd0);
        m_busy = 1'b0;
        tick(1);
        chk("fh_gnt", 32'(gnt), 32'd1);
        serve(7'h20, 1'b0, 2'd0, 1, 8'h00, 8'h00, 1'b1, 4'b0000);
        drain(20);

        // reset while ACTIVE, then a normal transaction
        sb_q.push_back(ev(K_GNT, 0, 8'h00));
        req = 4'b0001;
        wait_start(ok);
        req = '0;
        tick(2); m_busy = 1'b1; tick(3);
        rst = 1'b1; tick(1); rst = 1'b0; m_busy = 1'b0;
        chk("rm_gnt", 32'(gnt), 32'd0);
        chk("rm_mstart", 32'(m_start), 32'd0);
        chk("rm_done", 32'(done), 32'd0);
        chk("rm_err", 32'(err), 32'd0);
        tick(5);
        sb_q.push_back(ev(K_GNT, 0, 8'h00));
        sb_q.push_back(ev(K_WR, 0, 8'h10));
        sb_q.push_back(ev(K_DONE, 0, 8'h00));
        req = 4'b0001;
        serve(7'h20, 1'b0, 2'd0, 1, 8'h00, 8'h00, 1'b1, 4'b0000);
        drain(20);
        chk("rm_gnt_clear", 32'(gnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter START_TIMEOUT, default 1024, meaning the clk cycles to wait for master busy after start.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, with all logic on posedge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, N_REQ bits: per-requester transaction request level.
REQ-006 The block SHALL have port req_addr, input, N_REQ×7 bits: per-requester slave address.
REQ-007 The block SHALL have port req_rnw, input, N_REQ bits: per-requester read_nwrite.
REQ-008 The block SHALL have port req_size, input, N_REQ×2 bits: per-requester byte-size code.
REQ-009 The block SHALL have port req_wdata, input, N_REQ×8 bits, and port req_wvalid, input, N_REQ bits: per-requester write byte and its valid.
REQ-010 The block SHALL have port gnt, output, N_REQ bits: one-hot grant, held for the whole transaction.
REQ-011 The block SHALL have port wready, output, N_REQ bits: the master's dataReq routed to the granted requester only.
REQ-012 The block SHALL have port rdata, output, 8 bits, and port rvalid, output, N_REQ bits: read byte plus a one-cycle pulse to the granted requester.
REQ-013 The block SHALL have port done, output, N_REQ bits, and port err, output, N_REQ bits: one-cycle completion pulse and one-cycle timeout pulse.
REQ-014 The block SHALL have master-side outputs m_start (1), m_addr (7), m_rnw (1), m_size (2), m_data (8) and m_data_valid (1).
REQ-015 The block SHALL have master-side inputs m_busy (1), m_dataReq (1), m_newData (1) and m_data_o (8).

Function
REQ-016 The block SHALL implement FSM states IDLE, ISSUE, ACTIVE and FINISH.
REQ-017 In IDLE with any req bit set and m_busy low, the block SHALL select a winner by round-robin starting at index ptr+1 (mod N_REQ), set gnt one-hot, latch the winner's addr/rnw/size into registers and go to ISSUE the next cycle.
REQ-018 m_addr, m_rnw and m_size SHALL come from the latched registers, which are stable from ISSUE until IDLE.
REQ-019 In ISSUE the block SHALL assert m_start; when m_busy is sampled high it SHALL drop m_start and go to ACTIVE.
REQ-020 ISSUE SHALL count cycles; if the count reaches START_TIMEOUT-1 without m_busy, the block SHALL pulse err[winner] for one cycle, clear gnt and return to IDLE.
REQ-021 In ACTIVE, m_data and m_data_valid SHALL combinationally mux the granted requester's req_wdata and req_wvalid, and wready SHALL equal gnt AND m_dataReq.
REQ-022 The block SHALL register m_newData and, on its rising edge only, capture m_data_o into rdata and pulse rvalid[winner] for one cycle, giving exactly one pulse per read byte regardless of newData width.
REQ-023 In ACTIVE, when m_busy falls (registered falling edge), the block SHALL go to FINISH.
REQ-024 In FINISH the block SHALL pulse done[winner] for one cycle, set ptr to the winner index, clear gnt and return to IDLE, for a minimum idle-to-idle overhead of 2 cycles.
REQ-025 A requester dropping req after grant SHALL NOT abort the transaction; the grant SHALL persist until FINISH or timeout.
REQ-026 While gnt is nonzero, req changes SHALL NOT change gnt or the latched fields.
REQ-027 If exactly one requester is active, it SHALL be re-granted back-to-back with no starvation penalty.
REQ-028 With simultaneous requests, each requester SHALL be served at most once before any other pending requester is served again.
REQ-029 If m_busy is already high in IDLE (bus held by another master), the block SHALL NOT grant.
REQ-030 gnt SHALL be one-hot or zero at all times.

Reset
REQ-031 On rst high at a clk edge, the block SHALL set state=IDLE, gnt=0, ptr=N_REQ-1 (so requester 0 wins first), and clear the timeout count, the newData/busy edge registers, rvalid/done/err and m_start.
REQ-032 On rst high at a clk edge, the block SHALL set rdata=0 and the latched addr/rnw/size registers to 0.
REQ-033 Reset mid-transaction SHALL abandon the transaction without a done or err pulse; the master is reset by the same rst.

Structure
REQ-034 The FSM state encoding and the START_TIMEOUT default SHALL live in the shared package i2c_pkg.
REQ-035 The round-robin selector SHALL be one sub-module, rr_pick (inputs req and ptr, outputs one-hot winner and index); everything else stays flat.

Verification
REQ-036 The bench SHALL cover a single write: req[1]=1, addr=7'h50, rnw=0, size=2'd0, wdata=8'hA5 -> gnt=4'b0010, m_start until busy, byte A5 accepted on dataReq, done[1] one pulse, gnt=0.
REQ-037 The bench SHALL cover a read of 2 bytes: req[2], rnw=1, size=2'd1, slave returns 8'h3C then 8'hC3 -> exactly two rvalid[2] pulses with rdata 3C then C3, then done[2].
REQ-038 The bench SHALL cover contention: req=4'b1111 held for 4 transactions after reset -> grant order 0,1,2,3; with req=4'b0101 continuing -> order 0,2,0,2.
REQ-039 The bench SHALL cover a timeout: m_busy forced low, req[3] -> err[3] exactly START_TIMEOUT cycles after entering ISSUE, no done pulse, returns to IDLE.
REQ-040 The bench SHALL cover a foreign bus hold: m_busy high before req -> no gnt until busy low, then grant within 1 cycle.
REQ-041 The bench SHALL cover reset in ACTIVE mid-byte -> next cycle gnt=0, state IDLE, no done/err, and a subsequent req[0] is served normally.
